// File: rtl/pipeline_hazard_controller_if.sv
// Signal bundle between the hazard controller and the fetch/decode/execute datapath.
// The datapath (master) presents ID/EX status; the controller (slave) returns the stage controls.
interface pipeline_hazard_controller_if;
  logic [31:0] if_id_instr;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rt;
  logic        branch_taken;
  logic        pc_write;
  logic        pc_sel;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        halted;
  logic [15:0] stall_count;

  modport master (
    output if_id_instr, id_ex_mem_read, id_ex_rt, branch_taken,
    input  pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble, halted, stall_count
  );

  modport slave (
    input  if_id_instr, id_ex_mem_read, id_ex_rt, branch_taken,
    output pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble, halted, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Load-use stall, taken-branch squash and halt sequencing for a 5-stage MIPS pipeline.
// Stage controls are combinational from the registered state; reset forces a safe bubble pattern.
module pipeline_hazard_controller #(
  parameter int unsigned FLUSH_CYCLES      = 2,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter logic [31:0] HALT_WORD         = 32'h89ABCDEF
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_hazard_controller_if.slave   bus
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH, HALT} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic [5:0]  opcode_s;
  logic        reads_rt_s, hz_s, take_branch_s, freeze_s, count_en_s;
  logic        pc_write_s, pc_sel_s, if_id_write_s, if_id_flush_s, id_ex_bubble_s, halted_s;

  // Hazard decode, next-state selection and stage controls.
  always_comb begin
    opcode_s   = bus.if_id_instr[31:26];
    reads_rt_s = (opcode_s == 6'b000000) || (opcode_s == 6'b000100) || (opcode_s == 6'b101011);
    hz_s       = bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0) &&
                 ((bus.id_ex_rt == bus.if_id_instr[25:21]) ||
                  (reads_rt_s && (bus.id_ex_rt == bus.if_id_instr[20:16])));
    take_branch_s = bus.branch_taken && ((state_q == RUN) || (state_q == LOAD_STALL));

    state_d        = state_q;
    cnt_d          = cnt_q;
    freeze_s       = 1'b0;
    pc_write_s     = 1'b0;
    pc_sel_s       = 1'b0;
    if_id_write_s  = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_bubble_s = 1'b0;
    halted_s       = 1'b0;

    if (take_branch_s) begin
      pc_sel_s       = 1'b1;
      pc_write_s     = 1'b1;
      if_id_write_s  = 1'b1;
      if_id_flush_s  = 1'b1;
      id_ex_bubble_s = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_INIT;
      end else begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (bus.if_id_instr == HALT_WORD) begin
            id_ex_bubble_s = 1'b1;
            state_d        = HALT;
          end else if (hz_s) begin
            id_ex_bubble_s = 1'b1;
            freeze_s       = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = STALL_INIT;
            end else begin
              state_d = RUN;
            end
          end else begin
            pc_write_s    = 1'b1;
            if_id_write_s = 1'b1;
          end
        end
        LOAD_STALL: begin
          id_ex_bubble_s = 1'b1;
          freeze_s       = 1'b1;
          cnt_d          = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = RUN;
          end else begin
            state_d = LOAD_STALL;
          end
        end
        FLUSH: begin
          // EX already holds bubbles here, so a branch indication is stale.
          pc_write_s     = 1'b1;
          if_id_write_s  = 1'b1;
          if_id_flush_s  = 1'b1;
          id_ex_bubble_s = 1'b1;
          cnt_d          = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = RUN;
          end else begin
            state_d = FLUSH;
          end
        end
        HALT: begin
          id_ex_bubble_s = 1'b1;
          halted_s       = 1'b1;
        end
        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end

    count_en_s    = freeze_s || if_id_flush_s;
    stall_count_d = (count_en_s && (stall_count_q != 16'hFFFF)) ? stall_count_q + 16'd1
                                                                : stall_count_q;
  end

  // State, shared down-counter and saturating stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      cnt_q         <= 3'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.pc_write     = reset ? 1'b0 : pc_write_s;
  assign bus.pc_sel       = reset ? 1'b0 : pc_sel_s;
  assign bus.if_id_write  = reset ? 1'b0 : if_id_write_s;
  assign bus.if_id_flush  = reset ? 1'b1 : if_id_flush_s;
  assign bus.id_ex_bubble = reset ? 1'b1 : id_ex_bubble_s;
  assign bus.halted       = reset ? 1'b0 : halted_s;
  assign bus.stall_count  = reset ? 16'd0 : stall_count_q;

endmodule
